hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised, clocked successor to the decode-stage hazard comparator.
- Tracks destination registers of in-flight instructions in a DEPTH-entry shift scoreboard.
- Compares decode-stage source registers against the scoreboard and runs a small state machine that holds the front end for data hazards and branch shadows.
- Sits between the decode stage and the ID/EX pipeline register. Drives the fetch/decode hold and the bubble-injection control.

Parameters:
- REG_BITS, 3, width of a register specifier (2**REG_BITS architectural registers).
- DEPTH, 3, number of downstream stages tracked (entry 0 = EX, 1 = MEM, 2 = WB, ...); legal range 1..8.
- FWD_EN, 0, 0 = stall on any RAW match in any entry; 1 = full forwarding, stall only on load-use (entry 0 is a load).
- BR_SHADOW, 2, bubbles injected after a branch issues; legal range 1..15.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- id_valid, input, 1, decode holds a real instruction (low = encoded nop 16'h0000).
- id_rs, input, REG_BITS, first source register.
- id_rt, input, REG_BITS, second source register.
- id_rs_used, input, 1, instruction reads rs.
- id_rt_used, input, 1, instruction reads rt (low for immediate forms).
- id_writes, input, 1, instruction writes a register.
- id_rd, input, REG_BITS, destination register.
- id_is_load, input, 1, instruction is a memory load.
- id_is_branch, input, 1, instruction is a branch/jump.
- flush, input, 1, synchronous pipeline flush.
- stall, output, 1, high = hold PC and IF/ID.
- nop_n, output, 1, low = inject a bubble into ID/EX instead of the decode instruction.
- stall_cnt, output, CNT_W, count of cycles with nop_n low; saturates.

Behaviour:
- Scoreboard: DEPTH entries of {valid, rd, is_load}. Each clock, entry[k] <= entry[k-1] for k ≥ 1.
- Entry[0] <= {id_valid & id_writes & issue, id_rd, id_is_load}, where issue = nop_n.
- match_k = entry[k].valid & ((id_rs_used & rd == id_rs) | (id_rt_used & rd == id_rt)).
- FWD_EN=0: raw = OR of match_k over all k. FWD_EN=1: raw = match_0 & entry[0].is_load.
- States: IDLE, DSTALL, BSHADOW. 2-bit encoding; states go in the package.
- IDLE, id_valid & raw: go to DSTALL. Drive stall=1, nop_n=0 in the same cycle (combinational from the comparison).
- IDLE, id_valid & ~raw & id_is_branch: the branch issues this cycle (nop_n=1). Load shadow counter with BR_SHADOW and go to BSHADOW.
- DSTALL: re-evaluate raw each cycle. Stay while raw, with stall=1, nop_n=0. When raw clears, behave exactly as IDLE for that cycle and transition accordingly.
- BSHADOW: stall=1, nop_n=0. Counter decrements each cycle. Return to IDLE the cycle after the counter reaches 1.
  - Branch with BR_SHADOW=N yields exactly N bubbles.
  - No hazard evaluation occurs in BSHADOW.
- A data hazard on a branch takes priority. The branch is held in DSTALL; its shadow starts only when it issues.
- flush: on the next edge, all scoreboard valid bits clear, state goes to IDLE, and the shadow counter is 0.
  - flush overrides every other transition in the same cycle.
  - stall/nop_n in the flush cycle are computed normally.
- stall_cnt increments on every cycle with nop_n=0. It holds at all-ones and does not wrap.
- Reset (async, rst_n low, any time including mid-stall or mid-shadow):
  - scoreboard invalid, state IDLE, counter 0, stall_cnt 0.
  - Outputs while in reset: stall=0, nop_n=1.
- id_valid=0: no hazard, no branch. Behaves as a bubble passing through.
- Registers equal to 0 are ordinary registers; no hardwired-zero exemption.

Decomposition:
- Package hazard_pkg holds the state enumeration and the scoreboard entry struct {valid, rd, is_load}, parametrised by REG_BITS via localparam.
- One natural sub-module: hazard_match, a combinational per-entry source/destination comparator instantiated DEPTH times via generate.

Test Plan:
- FWD_EN=0, DEPTH=3: ADD r1 then ADD r2,r1,r3 back-to-back -> 3 cycles nop_n=0/stall=1, then the consumer issues; stall_cnt=3.
- FWD_EN=1: LD r4 then ADD r5,r4,r4 -> exactly 1 bubble. Non-load producer then consumer -> 0 bubbles.
- Immediate op with id_rt_used=0, rt field equal to an in-flight rd -> no stall.
- Branch issues, BR_SHADOW=2 -> branch passes with nop_n=1, next 2 cycles nop_n=0, then IDLE; branch reading a pending rd stalls first, then shadow.
- flush asserted during DSTALL with 2 valid entries -> next cycle IDLE, no further stall for the previously conflicting consumer.
- rst_n pulsed low mid-BSHADOW (asynchronous, between edges) -> stall=0, nop_n=1, stall_cnt=0 immediately; CNT_W=2 run of 5 stall cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard scoreboard: FSM state codes and
// the per-stage scoreboard entry.
package hazard_pkg;

    // Widest register specifier an entry can hold; narrower REG_BITS values
    // are zero-extended into this field.
    localparam int REG_BITS_MAX = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DSTALL  = 2'd1;
    localparam logic [1:0] ST_BSHADOW = 2'd2;

    typedef struct packed {
        logic                    valid;
        logic [REG_BITS_MAX-1:0] rd;
        logic                    isLoad;
    } scbEntry_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational RAW comparator for one scoreboard entry: flags when a live
// in-flight destination equals either source the decode instruction reads.
module hazard_match
    import hazard_pkg::*;
(
    input  logic                    entValid,
    input  logic [REG_BITS_MAX-1:0] entRd,
    input  logic [REG_BITS_MAX-1:0] rs,
    input  logic [REG_BITS_MAX-1:0] rt,
    input  logic                    rsUsed,
    input  logic                    rtUsed,
    output logic                    match
);

    // Register 0 is an ordinary register here, so no zero exemption.
    assign match = entValid & ((rsUsed & (entRd == rs)) | (rtUsed & (entRd == rt)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations for DEPTH
// downstream stages, holds the front end on RAW hazards and inserts
// BR_SHADOW bubbles behind every issued branch.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_BITS  = 3,
    parameter int DEPTH     = 3,
    parameter int FWD_EN    = 0,
    parameter int BR_SHADOW = 2,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic                id_writes,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_is_load,
    input  logic                id_is_branch,
    input  logic                flush,
    output logic                stall,
    output logic                nop_n,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [3:0] SHADOW_INIT = 4'(BR_SHADOW);

    scbEntry_t [DEPTH-1:0]   scb;
    logic      [DEPTH-1:0]   match;
    logic      [DEPTH-1:0]   isLoadVec;
    logic [REG_BITS_MAX-1:0] rsExt, rtExt;
    logic [1:0]              state, stateNxt;
    logic [3:0]              shCnt, shCntNxt;
    logic                    raw;
    logic                    unusedBits;

    assign rsExt = REG_BITS_MAX'(id_rs);
    assign rtExt = REG_BITS_MAX'(id_rt);

    for (genvar k = 0; k < DEPTH; k++) begin : gMatch
        hazard_match uMatch (
            .entValid (scb[k].valid),
            .entRd    (scb[k].rd),
            .rs       (rsExt),
            .rt       (rtExt),
            .rsUsed   (id_rs_used),
            .rtUsed   (id_rt_used),
            .match    (match[k])
        );
        assign isLoadVec[k] = scb[k].isLoad;
    end

    // With forwarding only a load sitting in EX cannot be bypassed in time.
    if (FWD_EN != 0) begin : gFwd
        assign raw = match[0] & isLoadVec[0];
    end else begin : gNoFwd
        assign raw = |match;
    end

    // Whichever of these the chosen forwarding mode ignores is folded here.
    assign unusedBits = ^{isLoadVec, match};

    // Next-state and front-end hold; a hazard on a branch wins over its
    // shadow, which only starts once the branch actually issues.
    always_comb begin
        stall    = 1'b0;
        nop_n    = 1'b1;
        stateNxt = state;
        shCntNxt = shCnt;
        case (state)
            ST_BSHADOW: begin
                stall    = 1'b1;
                nop_n    = 1'b0;
                shCntNxt = shCnt - 4'd1;
                if (shCnt <= 4'd1) begin
                    stateNxt = ST_IDLE;
                    shCntNxt = 4'd0;
                end
            end
            default: begin
                if (id_valid && raw) begin
                    stall    = 1'b1;
                    nop_n    = 1'b0;
                    stateNxt = ST_DSTALL;
                end else if (id_valid && id_is_branch) begin
                    stateNxt = ST_BSHADOW;
                    shCntNxt = SHADOW_INIT;
                end else begin
                    stateNxt = ST_IDLE;
                end
            end
        endcase
        if (flush) begin
            stateNxt = ST_IDLE;
            shCntNxt = 4'd0;
        end
    end

    // FSM and shadow counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            shCnt <= 4'd0;
        end else begin
            state <= stateNxt;
            shCnt <= shCntNxt;
        end
    end

    // Scoreboard shift: a bubble enters entry 0 whenever decode is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scb <= '0;
        end else if (flush) begin
            scb <= '0;
        end else begin
            scb[0].valid  <= id_valid & id_writes & nop_n;
            scb[0].rd     <= REG_BITS_MAX'(id_rd);
            scb[0].isLoad <= id_is_load;
            for (int k = 1; k < DEPTH; k++) scb[k] <= scb[k-1];
        end
    end

    // Saturating count of bubble cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!nop_n && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances share one decode stream
// (A: no forwarding, B: forwarding, C: 2-bit stall counter). Expected
// {stall,nop_n} pairs are queued as each instruction is driven and popped
// when the outputs are sampled on the falling edge.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs_used, id_rt_used, id_writes, id_is_load, id_is_branch, flush;
    logic [2:0] id_rs, id_rt, id_rd;
    logic       stallA, nopA, stallB, nopB, stallC, nopC;
    logic [15:0] cntA, cntB;
    logic [1:0]  cntC;

    int errors = 0;
    int checks = 0;
    logic [1:0] expQ[$];

    localparam logic [1:0] ISS = 2'b01;  // {stall,nop_n}: instruction issues
    localparam logic [1:0] BUB = 2'b10;  // {stall,nop_n}: held, bubble injected

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_BITS(3), .DEPTH(3), .FWD_EN(0), .BR_SHADOW(2), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_writes(id_writes), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .flush(flush),
        .stall(stallA), .nop_n(nopA), .stall_cnt(cntA));

    hazard_scoreboard #(.REG_BITS(3), .DEPTH(3), .FWD_EN(1), .BR_SHADOW(2), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_writes(id_writes), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .flush(flush),
        .stall(stallB), .nop_n(nopB), .stall_cnt(cntB));

    hazard_scoreboard #(.REG_BITS(3), .DEPTH(3), .FWD_EN(0), .BR_SHADOW(2), .CNT_W(2)) dutC (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_writes(id_writes), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .flush(flush),
        .stall(stallC), .nop_n(nopC), .stall_cnt(cntC));

    typedef struct packed {
        logic v; logic [2:0] rs; logic [2:0] rt; logic rsU; logic rtU;
        logic wr; logic [2:0] rd; logic ld; logic br; logic f;
    } instr_t;

    function automatic instr_t mk(input logic v, input int rs, input int rt, input logic rsU,
                                  input logic rtU, input logic wr, input int rd,
                                  input logic ld, input logic br);
        instr_t i;
        i.v = v; i.rs = 3'(rs); i.rt = 3'(rt); i.rsU = rsU; i.rtU = rtU;
        i.wr = wr; i.rd = 3'(rd); i.ld = ld; i.br = br; i.f = 1'b0;
        return i;
    endfunction

    function automatic instr_t alu(input int rd, input int rs, input int rt);
        return mk(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, 1'b0, 1'b0);
    endfunction
    function automatic instr_t ldI(input int rd, input int rs);
        return mk(1'b1, rs, 0, 1'b1, 1'b0, 1'b1, rd, 1'b1, 1'b0);
    endfunction
    function automatic instr_t imm(input int rd, input int rs, input int rt);
        return mk(1'b1, rs, rt, 1'b1, 1'b0, 1'b1, rd, 1'b0, 1'b0);
    endfunction
    function automatic instr_t brI(input int rs);
        return mk(1'b1, rs, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    endfunction
    function automatic instr_t useI(input int rs, input int rt);
        return mk(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endfunction
    function automatic instr_t nopI();
        return mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    task automatic drive(input instr_t i);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rs_used = i.rsU; id_rt_used = i.rtU;
        id_writes = i.wr; id_rd = i.rd; id_is_load = i.ld; id_is_branch = i.br; flush = i.f;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        drive(nopI());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(brI(1));
        @(negedge clk);
        checks++; if ({stallA, nopA} !== ISS) begin errors++; $display("FAIL reset_outA got %b want %b", {stallA, nopA}, ISS); end
        checks++; if ({stallB, nopB} !== ISS) begin errors++; $display("FAIL reset_outB got %b want %b", {stallB, nopB}, ISS); end
        checks++; if (cntA !== 16'd0) begin errors++; $display("FAIL reset_cntA got %0d want 0", cntA); end
        checks++; if (cntB !== 16'd0) begin errors++; $display("FAIL reset_cntB got %0d want 0", cntB); end
        checks++; if (cntC !== 2'd0) begin errors++; $display("FAIL reset_cntC got %0d want 0", cntC); end
        doReset();
    endtask

    // ADD r1 ; ADD r2,r1,r3. A stalls three cycles, B forwards with no bubble.
    task automatic test_raw_stall();
        instr_t seq[6]; logic [1:0] exA[6]; logic [1:0] e;
        seq[0] = alu(1, 2, 3); exA[0] = ISS;
        for (int i = 1; i < 4; i++) begin seq[i] = alu(2, 1, 3); exA[i] = BUB; end
        seq[4] = alu(2, 1, 3); exA[4] = ISS;
        seq[5] = nopI();       exA[5] = ISS;
        for (int i = 0; i < 6; i++) begin
            drive(seq[i]); expQ.push_back(exA[i]); expQ.push_back(ISS);
            @(negedge clk);
            e = expQ.pop_front(); checks++;
            if ({stallA, nopA} !== e) begin errors++; $display("FAIL raw_A[%0d] got %b want %b", i, {stallA, nopA}, e); end
            e = expQ.pop_front(); checks++;
            if ({stallB, nopB} !== e) begin errors++; $display("FAIL raw_fwdB[%0d] got %b want %b", i, {stallB, nopB}, e); end
            if (i == 5) begin
                checks++; if (cntA !== 16'd3) begin errors++; $display("FAIL raw_cntA got %0d want 3", cntA); end
                checks++; if (cntB !== 16'd0) begin errors++; $display("FAIL raw_cntB got %0d want 0", cntB); end
            end
            @(posedge clk); #1;
        end
        doReset();
    endtask

    // LD r4 ; ADD r5,r4,r4 with forwarding: exactly one bubble.
    task automatic test_load_use();
        instr_t seq[4]; logic [1:0] ex[4]; logic [1:0] e;
        seq[0] = ldI(4, 0);    ex[0] = ISS;
        seq[1] = alu(5, 4, 4); ex[1] = BUB;
        seq[2] = alu(5, 4, 4); ex[2] = ISS;
        seq[3] = nopI();       ex[3] = ISS;
        for (int i = 0; i < 4; i++) begin
            drive(seq[i]); expQ.push_back(ex[i]);
            @(negedge clk);
            e = expQ.pop_front(); checks++;
            if ({stallB, nopB} !== e) begin errors++; $display("FAIL loaduse[%0d] got %b want %b", i, {stallB, nopB}, e); end
            if (i == 3) begin
                checks++; if (cntB !== 16'd1) begin errors++; $display("FAIL loaduse_cnt got %0d want 1", cntB); end
            end
            @(posedge clk); #1;
        end
        doReset();
    endtask

    // Unused rt, invalid decode slot and r0 as an ordinary register.
    task automatic test_immediate();
        instr_t seq[8]; logic [1:0] ex[8]; logic [1:0] e;
        seq[0] = alu(6, 1, 2); ex[0] = ISS;
        seq[1] = imm(7, 1, 6); ex[1] = ISS;
        seq[2] = mk(1'b0, 6, 6, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b1); ex[2] = ISS;
        seq[3] = alu(0, 1, 2); ex[3] = ISS;
        for (int i = 4; i < 7; i++) begin seq[i] = alu(3, 0, 0); ex[i] = BUB; end
        seq[7] = alu(3, 0, 0); ex[7] = ISS;
        for (int i = 0; i < 8; i++) begin
            drive(seq[i]); expQ.push_back(ex[i]);
            @(negedge clk);
            e = expQ.pop_front(); checks++;
            if ({stallA, nopA} !== e) begin errors++; $display("FAIL imm[%0d] got %b want %b", i, {stallA, nopA}, e); end
            @(posedge clk); #1;
        end
        doReset();
    endtask

    // Plain branch shadow, then a branch waiting on r3 before its shadow.
    task automatic test_branch();
        instr_t seq[12]; logic [1:0] ex[12]; logic [1:0] e;
        seq[0] = brI(1);      ex[0] = ISS;
        seq[1] = useI(6, 7);  ex[1] = BUB;
        seq[2] = useI(6, 7);  ex[2] = BUB;
        seq[3] = useI(6, 7);  ex[3] = ISS;
        seq[4] = alu(3, 1, 1); ex[4] = ISS;
        for (int i = 5; i < 8; i++) begin seq[i] = brI(3); ex[i] = BUB; end
        seq[8] = brI(3);      ex[8] = ISS;
        seq[9] = useI(6, 7);  ex[9] = BUB;
        seq[10] = useI(6, 7); ex[10] = BUB;
        seq[11] = useI(6, 7); ex[11] = ISS;
        for (int i = 0; i < 12; i++) begin
            drive(seq[i]); expQ.push_back(ex[i]);
            @(negedge clk);
            e = expQ.pop_front(); checks++;
            if ({stallA, nopA} !== e) begin errors++; $display("FAIL branch[%0d] got %b want %b", i, {stallA, nopA}, e); end
            @(posedge clk); #1;
        end
        drive(nopI());
        @(negedge clk);
        checks++; if (cntA !== 16'd7) begin errors++; $display("FAIL branch_cnt got %0d want 7", cntA); end
        doReset();
    endtask

    // Flush during DSTALL with two live entries, then flush cutting a shadow.
    task automatic test_flush();
        instr_t seq[7]; logic [1:0] ex[7]; logic [1:0] e;
        seq[0] = alu(1, 4, 5); ex[0] = ISS;
        seq[1] = alu(2, 4, 5); ex[1] = ISS;
        seq[2] = alu(3, 1, 2); seq[2].f = 1'b1; ex[2] = BUB;
        seq[3] = alu(3, 1, 2); ex[3] = ISS;
        seq[4] = brI(6);       ex[4] = ISS;
        seq[5] = nopI();       seq[5].f = 1'b1; ex[5] = BUB;
        seq[6] = nopI();       ex[6] = ISS;
        for (int i = 0; i < 7; i++) begin
            drive(seq[i]); expQ.push_back(ex[i]);
            @(negedge clk);
            e = expQ.pop_front(); checks++;
            if ({stallA, nopA} !== e) begin errors++; $display("FAIL flush[%0d] got %b want %b", i, {stallA, nopA}, e); end
            @(posedge clk); #1;
        end
        doReset();
    endtask

    // Asynchronous reset between edges in the middle of a branch shadow.
    task automatic test_async_reset();
        instr_t seq[7]; logic [1:0] ex[7]; logic [1:0] e;
        seq[0] = alu(1, 2, 3); ex[0] = ISS;
        for (int i = 1; i < 4; i++) begin seq[i] = alu(2, 1, 3); ex[i] = BUB; end
        seq[4] = alu(2, 1, 3); ex[4] = ISS;
        seq[5] = brI(7);       ex[5] = ISS;
        seq[6] = nopI();       ex[6] = BUB;
        for (int i = 0; i < 7; i++) begin
            drive(seq[i]); expQ.push_back(ex[i]);
            @(negedge clk);
            e = expQ.pop_front(); checks++;
            if ({stallA, nopA} !== e) begin errors++; $display("FAIL arst_pre[%0d] got %b want %b", i, {stallA, nopA}, e); end
            if (i < 6) begin @(posedge clk); #1; end
        end
        checks++; if (cntA !== 16'd3) begin errors++; $display("FAIL arst_cnt_before got %0d want 3", cntA); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (stallA !== 1'b0) begin errors++; $display("FAIL arst_stall got %b want 0", stallA); end
        checks++; if (nopA !== 1'b1) begin errors++; $display("FAIL arst_nop got %b want 1", nopA); end
        checks++; if (cntA !== 16'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", cntA); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({stallA, nopA} !== ISS) begin errors++; $display("FAIL arst_after got %b want %b", {stallA, nopA}, ISS); end
        @(posedge clk); #1;
        doReset();
    endtask

    // Five bubble cycles: the 2-bit counter pins at 3, the 16-bit one reads 5.
    task automatic test_saturate();
        instr_t seq[9]; logic [1:0] ex[9]; logic [1:0] e;
        seq[0] = alu(1, 2, 3); ex[0] = ISS;
        for (int i = 1; i < 4; i++) begin seq[i] = alu(2, 1, 3); ex[i] = BUB; end
        seq[4] = alu(2, 1, 3); ex[4] = ISS;
        seq[5] = brI(7);       ex[5] = ISS;
        seq[6] = nopI();       ex[6] = BUB;
        seq[7] = nopI();       ex[7] = BUB;
        seq[8] = nopI();       ex[8] = ISS;
        for (int i = 0; i < 9; i++) begin
            drive(seq[i]); expQ.push_back(ex[i]);
            @(negedge clk);
            e = expQ.pop_front(); checks++;
            if ({stallC, nopC} !== e) begin errors++; $display("FAIL sat[%0d] got %b want %b", i, {stallC, nopC}, e); end
            if (i == 4) begin
                checks++; if (cntC !== 2'd3) begin errors++; $display("FAIL sat_cnt_mid got %0d want 3", cntC); end
            end
            @(posedge clk); #1;
        end
        drive(nopI());
        @(negedge clk);
        checks++; if (cntC !== 2'd3) begin errors++; $display("FAIL sat_cnt_end got %0d want 3", cntC); end
        checks++; if (cntA !== 16'd5) begin errors++; $display("FAIL sat_cntA got %0d want 5", cntA); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_load_use();
        test_immediate();
        test_branch();
        test_flush();
        test_async_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
